perspective_divide: RTL and testbench



---
 rtl/perspective_divide.sv | 185 ++++++++++++++++++
 tb/tb_perspective_divide.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/perspective_divide.sv
// Perspective divide of one homogeneous vertex with a shared restoring divider, then NDC -> screen/depth.
// Latency 3*DIV_ITERS+3 cycles (2 on early reject); ready_out low while busy, valid_in dropped then.
module perspective_divide #(
    parameter int WIDTH     = 1280,
    parameter int HEIGHT    = 720,
    parameter int DIV_ITERS = 24
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] pos [3:0],
    input  logic        valid_in,
    output logic        ready_out,
    output logic        valid_out,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic [15:0] depth_out,
    output logic        clipped_out
);

    typedef enum logic [2:0] {IDLE, UNPACK, DIV_X, DIV_Y, DIV_Z, MAP, DONE} state_t;

    typedef struct packed {
        logic               clip;
        logic signed [17:0] ndc;
    } conv_t;

    localparam int CW = $clog2(DIV_ITERS);
    localparam logic [CW-1:0] LAST = CW'(DIV_ITERS - 1);

    // Quotient q is the mantissa ratio scaled by 2^(DIV_ITERS-1); Q2.16 magnitude is q*2^(e-(DIV_ITERS-1)+16).
    function automatic conv_t to_ndc(input logic [31:0] c, input logic [31:0] w,
                                     input logic [DIV_ITERS-1:0] q);
        conv_t      res;
        int         rs;
        logic [31:0] mag;
        logic       sat;
        res = '0;
        mag = '0;
        sat = 1'b0;
        rs  = DIV_ITERS - 17 - (int'(c[30:23]) - int'(w[30:23]));
        if (c[30:23] != 8'd0) begin
            if (rs < 0)
                sat = 1'b1;
            else if (rs < 32)
                mag = 32'(q) >> rs;
            if (mag >= 32'h0002_0000)
                sat = 1'b1;
            if (sat)
                mag = 32'h0001_FFFF;
            res.clip = sat || (mag > 32'h0001_0000);
            res.ndc  = (c[31] ^ w[31]) ? -$signed(mag[17:0]) : $signed(mag[17:0]);
        end
        return res;
    endfunction

    state_t               state, state_n;
    logic [31:0]          pos_r [3:0];
    logic [24:0]          rem, rem_n;
    logic [DIV_ITERS-1:0] quo, quo_n;
    logic [CW-1:0]        cnt;
    logic signed [17:0]   ndc_x, ndc_y, ndc_z;
    logic                 clip_acc;
    logic [23:0]          divisor;
    logic                 ge, last, reject;
    logic [31:0]          cur_c, nxt_c;
    conv_t                conv;
    int                   hx, vy, dz;
    logic [10:0]          hcount_n;
    logic [9:0]           vcount_n;
    logic [15:0]          depth_n;

    always_ff @(posedge clk_in) begin
        if (rst_in)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        ready_out = 1'b0;
        valid_out = 1'b0;
        case (state)
            IDLE: begin
                ready_out = 1'b1;
                if (valid_in)
                    state_n = UNPACK;
            end
            UNPACK:  state_n = reject ? DONE : DIV_X;
            DIV_X:   if (last) state_n = DIV_Y;
            DIV_Y:   if (last) state_n = DIV_Z;
            DIV_Z:   if (last) state_n = MAP;
            MAP:     state_n = DONE;
            DONE: begin
                valid_out = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        divisor = {1'b1, pos_r[0][22:0]};
        reject  = pos_r[0][31] || (pos_r[0][30:23] == 8'd0);
        last    = (cnt == LAST);
        ge      = (rem >= {1'b0, divisor});
        rem_n   = (ge ? rem - {1'b0, divisor} : rem) << 1;
        quo_n   = {quo[DIV_ITERS-2:0], ge};
        cur_c   = (state == DIV_X) ? pos_r[3] : (state == DIV_Y) ? pos_r[2] : pos_r[1];
        nxt_c   = (state == DIV_X) ? pos_r[2] : pos_r[1];
        conv    = to_ndc(cur_c, pos_r[0], quo_n);
    end

    always_comb begin
        hx = ((int'(ndc_x) + 65536) * WIDTH) >>> 17;
        vy = ((65536 - int'(ndc_y)) * HEIGHT) >>> 17;
        dz = (int'(ndc_z) + 65536) >>> 1;
        hcount_n = (hx < 0) ? 11'd0 : (hx > WIDTH - 1)  ? 11'(WIDTH - 1)  : 11'(hx);
        vcount_n = (vy < 0) ? 10'd0 : (vy > HEIGHT - 1) ? 10'(HEIGHT - 1) : 10'(vy);
        depth_n  = (dz < 0) ? 16'd0 : (dz > 65535)      ? 16'hFFFF        : 16'(dz);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < 4; i++)
                pos_r[i] <= '0;
            rem         <= '0;
            quo         <= '0;
            cnt         <= '0;
            ndc_x       <= '0;
            ndc_y       <= '0;
            ndc_z       <= '0;
            clip_acc    <= 1'b0;
            hcount_out  <= '0;
            vcount_out  <= '0;
            depth_out   <= '0;
            clipped_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in)
                        for (int i = 0; i < 4; i++)
                            pos_r[i] <= pos[i];
                end
                UNPACK: begin
                    rem      <= {2'b01, pos_r[3][22:0]};
                    quo      <= '0;
                    cnt      <= '0;
                    clip_acc <= 1'b0;
                    if (reject) begin
                        hcount_out  <= '0;
                        vcount_out  <= '0;
                        depth_out   <= '0;
                        clipped_out <= 1'b1;
                    end
                end
                DIV_X, DIV_Y, DIV_Z: begin
                    rem <= rem_n;
                    quo <= quo_n;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        // Preload the next component so the divider runs back to back.
                        cnt      <= '0;
                        quo      <= '0;
                        rem      <= {2'b01, nxt_c[22:0]};
                        clip_acc <= clip_acc | conv.clip;
                        case (state)
                            DIV_X:   ndc_x <= conv.ndc;
                            DIV_Y:   ndc_y <= conv.ndc;
                            default: ndc_z <= conv.ndc;
                        endcase
                    end
                end
                MAP: begin
                    hcount_out  <= hcount_n;
                    vcount_out  <= vcount_n;
                    depth_out   <= depth_n;
                    clipped_out <= clip_acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_perspective_divide.sv
// Directed bench for perspective_divide: latency, mapping, boundaries, clip/reject, busy drop, mid-op reset.
module tb_perspective_divide;

    localparam logic [31:0] F_0    = 32'h0000_0000;
    localparam logic [31:0] F_1    = 32'h3F80_0000;
    localparam logic [31:0] F_M1   = 32'hBF80_0000;
    localparam logic [31:0] F_2    = 32'h4000_0000;
    localparam logic [31:0] F_3    = 32'h4040_0000;
    localparam logic [31:0] F_4    = 32'h4080_0000;
    localparam logic [31:0] F_HALF = 32'h3F00_0000;
    localparam logic [31:0] F_MH   = 32'hBF00_0000;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] pos [3:0];
    logic        valid_in;
    logic        ready_out;
    logic        valid_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic [15:0] depth_out;
    logic        clipped_out;

    int checks = 0;
    int errors = 0;
    int vcnt;

    always #5 clk_in = ~clk_in;

    perspective_divide dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .pos         (pos),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .valid_out   (valid_out),
        .hcount_out  (hcount_out),
        .vcount_out  (vcount_out),
        .depth_out   (depth_out),
        .clipped_out (clipped_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] z, input logic [31:0] w);
        pos[3] = x;
        pos[2] = y;
        pos[1] = z;
        pos[0] = w;
    endtask

    // Accepts one vertex, then counts cycles until valid_out; optionally fires a dropped pulse.
    task automatic vertex(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] z, input logic [31:0] w, input int drop_at,
                          input int exp_lat, input logic [31:0] eh, input logic [31:0] ev,
                          input logic [31:0] ed, input logic [31:0] ec);
        int   lat;
        logic rdy_busy;
        @(negedge clk_in);
        check({tag, ".ready_idle"}, 32'(ready_out), 32'd1);
        drive(x, y, z, w);
        valid_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        valid_in = 1'b0;
        lat      = -1;
        rdy_busy = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            if (valid_out) begin
                lat = n;
                break;
            end
            if (ready_out)
                rdy_busy = 1'b1;
            if (n == drop_at) begin
                drive(F_2, F_0, F_0, F_1);
                valid_in = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
            @(negedge clk_in);
        end
        valid_in = 1'b0;
        check({tag, ".latency"},   32'(lat),         32'(exp_lat));
        check({tag, ".ready_busy"}, 32'(rdy_busy),   32'd0);
        check({tag, ".hcount"},    32'(hcount_out),  eh);
        check({tag, ".vcount"},    32'(vcount_out),  ev);
        check({tag, ".depth"},     32'(depth_out),   ed);
        check({tag, ".clipped"},   32'(clipped_out), ec);
    endtask

    initial begin
        rst_in   = 1'b1;
        valid_in = 1'b0;
        drive(F_0, F_0, F_0, F_0);
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        check("reset.ready",   32'(ready_out),   32'd1);
        check("reset.valid",   32'(valid_out),   32'd0);
        check("reset.hcount",  32'(hcount_out),  32'd0);
        check("reset.vcount",  32'(vcount_out),  32'd0);
        check("reset.depth",   32'(depth_out),   32'd0);
        check("reset.clipped", 32'(clipped_out), 32'd0);

        vertex("t1_origin",  F_0,  F_0,  F_0, F_1,  -1, 75, 640,  360, 32'h8000, 0);
        vertex("t2_half",    F_2,  F_2,  F_0, F_4,  -1, 75, 960,  180, 32'h8000, 0);
        vertex("t3_edge",    F_M1, F_M1, F_1, F_1,  -1, 75, 0,    719, 32'hFFFF, 0);
        vertex("t4_clip",    F_3,  F_0,  F_0, F_1,  -1, 75, 1279, 360, 32'h8000, 1);
        vertex("t4_w_zero",  F_1,  F_1,  F_1, F_0,  -1, 2,  0,    0,   0,        1);
        vertex("t4_w_neg",   F_1,  F_1,  F_1, F_M1, -1, 2,  0,    0,   0,        1);

        vertex("t5_busy",    F_2,  F_2,  F_0, F_4,  10, 75, 960,  180, 32'h8000, 0);
        vcnt = 0;
        repeat (120) begin
            @(negedge clk_in);
            if (valid_out)
                vcnt++;
        end
        check("t5_busy.no_second_valid", 32'(vcnt),       32'd0);
        check("t5_busy.hold_hcount",     32'(hcount_out), 32'd960);

        // Reset pulse landing in DIV_Y (cycle 30 after the accept edge).
        @(negedge clk_in);
        drive(F_HALF, F_MH, F_MH, F_1);
        valid_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        valid_in = 1'b0;
        vcnt = 0;
        repeat (29) begin
            if (valid_out)
                vcnt++;
            @(negedge clk_in);
        end
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        check("t6_rst.ready",   32'(ready_out),   32'd1);
        check("t6_rst.valid",   32'(valid_out),   32'd0);
        check("t6_rst.hcount",  32'(hcount_out),  32'd0);
        check("t6_rst.vcount",  32'(vcount_out),  32'd0);
        check("t6_rst.depth",   32'(depth_out),   32'd0);
        check("t6_rst.clipped", 32'(clipped_out), 32'd0);
        repeat (100) begin
            @(negedge clk_in);
            if (valid_out)
                vcnt++;
        end
        check("t6_rst.no_valid", 32'(vcnt), 32'd0);
        vertex("t6_after", F_HALF, F_MH, F_MH, F_1, -1, 75, 960, 540, 32'h4000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
